// File: rtl/multi_ch_trigger_if.sv
// Stream bus for the multi-channel trigger:
// raw ADC beats in, framed beats out.
interface multi_ch_trigger_if #(
  parameter int N_CH             = 4,
  parameter int TDATA_WIDTH      = 256,
  parameter int TIME_STAMP_WIDTH = 48
);
  logic [N_CH*TDATA_WIDTH-1:0]      TDATA;
  logic [N_CH-1:0]                  TVALID;
  logic                             ALL_MODULE_READY;
  logic [N_CH*TDATA_WIDTH-1:0]      DOUT;
  logic [N_CH-1:0]                  VALID;
  logic [N_CH-1:0]                  FRAME_START;
  logic [N_CH-1:0]                  FRAME_END;
  logic [N_CH-1:0]                  TRUNCATED;
  logic [N_CH*TIME_STAMP_WIDTH-1:0] TRIG_TIME;

  modport master (
    output TDATA, TVALID, ALL_MODULE_READY,
    input  DOUT, VALID, FRAME_START,
    input  FRAME_END, TRUNCATED, TRIG_TIME
  );

  modport slave (
    input  TDATA, TVALID, ALL_MODULE_READY,
    output DOUT, VALID, FRAME_START,
    output FRAME_END, TRUNCATED, TRIG_TIME
  );
endinterface

// File: rtl/multi_ch_trigger.sv
// Per-channel threshold trigger with
// post-trigger window and length cap.
module multi_ch_trigger #(
  parameter int N_CH                 = 4,
  parameter int TDATA_WIDTH          = 256,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int TIME_STAMP_WIDTH     = 48,
  parameter int MAX_FRAME_LEN        = 50,
  parameter int POST_CNT_WIDTH       = 8
) (
  input  logic                            CLK,
  input  logic                            RESET,
  multi_ch_trigger_if.slave               bus,
  input  logic [N_CH-1:0]                 CH_ENABLE,
  input  logic                            MODE,
  input  logic [ADC_RESOLUTION_WIDTH:0]   THRESHOLD_VAL,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
  input  logic [POST_CNT_WIDTH-1:0]       POST_ACQUI_LEN,
  input  logic [TIME_STAMP_WIDTH-1:0]     CURRENT_TIME
);

  localparam int ARW = ADC_RESOLUTION_WIDTH;
  localparam int TW  = TDATA_WIDTH;
  localparam int TSW = TIME_STAMP_WIDTH;
  localparam int PCW = POST_CNT_WIDTH;
  localparam int SPT = TDATA_WIDTH / 16;
  localparam int DW  = ARW + 2;
  localparam int LW  = $clog2(MAX_FRAME_LEN + 1);

  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_FRAME_LEN);
  localparam logic [LW-1:0] ONE_LEN = LW'(1);

  typedef enum logic {
    IDLE,
    ACQ
  } state_e;

  state_e         state_q [N_CH];
  state_e         state_d [N_CH];
  logic [PCW-1:0] post_q  [N_CH];
  logic [PCW-1:0] post_d  [N_CH];
  logic [LW-1:0]  len_q   [N_CH];
  logic [LW-1:0]  len_d   [N_CH];

  logic [N_CH*TW-1:0]  dout_q,  dout_d;
  logic [N_CH-1:0]     valid_q, valid_d;
  logic [N_CH-1:0]     fs_q,    fs_d;
  logic [N_CH-1:0]     fe_q,    fe_d;
  logic [N_CH-1:0]     tr_q,    tr_d;
  logic [N_CH*TSW-1:0] ttime_q, ttime_d;

  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] trig;
  logic            coinc;

  function automatic logic above_thr(
    input logic [ARW-1:0] smp,
    input logic [ARW-1:0] bl,
    input logic [ARW:0]   th
  );
    logic signed [DW-1:0] diff;
    logic signed [DW-1:0] lim;
    diff = $signed({{2{smp[ARW-1]}}, smp})
         - $signed({{2{bl[ARW-1]}}, bl});
    lim  = $signed({th[ARW], th});
    return diff > lim;
  endfunction

  // Hit detect: any sample of a valid,
  // enabled beat above baseline+threshold.
  always_comb begin
    hit = '0;
    for (int c = 0; c < N_CH; c++) begin
      for (int k = 0; k < SPT; k++) begin
        hit[c] = hit[c] | above_thr(
          bus.TDATA[c*TW+16*k+15 -: ARW],
          BASELINE, THRESHOLD_VAL);
      end
      hit[c] = hit[c] & bus.TVALID[c]
                      & CH_ENABLE[c];
    end
  end

  // Trigger source: own hit, or any hit
  // fanned out to enabled channels.
  always_comb begin
    coinc = |hit;
    trig  = '0;
    for (int c = 0; c < N_CH; c++) begin
      trig[c] = MODE ? (coinc & CH_ENABLE[c])
                     : hit[c];
    end
  end

  // Per-channel frame FSM and output stage.
  always_comb begin
    logic [PCW-1:0] pn;
    dout_d  = bus.TDATA;
    ttime_d = ttime_q;
    valid_d = '0;
    fs_d    = '0;
    fe_d    = '0;
    tr_d    = '0;
    pn      = '0;
    for (int c = 0; c < N_CH; c++) begin
      state_d[c] = state_q[c];
      post_d[c]  = post_q[c];
      len_d[c]   = len_q[c];
      pn         = '0;
      unique case (state_q[c])
        IDLE: begin
          if (trig[c] && bus.ALL_MODULE_READY) begin
            valid_d[c] = 1'b1;
            fs_d[c]    = 1'b1;
            ttime_d[c*TSW +: TSW] = CURRENT_TIME;
            post_d[c]  = POST_ACQUI_LEN;
            len_d[c]   = ONE_LEN;
            state_d[c] = ACQ;
            if (MAX_LEN == ONE_LEN) begin
              fe_d[c]    = 1'b1;
              tr_d[c]    = 1'b1;
              post_d[c]  = '0;
              len_d[c]   = '0;
              state_d[c] = IDLE;
            end
          end
        end
        ACQ: begin
          if (bus.TVALID[c]) begin
            valid_d[c] = 1'b1;
            len_d[c]   = len_q[c] + 1'b1;
            if (trig[c]) begin
              pn = POST_ACQUI_LEN;
            end else if (post_q[c] != '0) begin
              pn = post_q[c] - 1'b1;
            end
            post_d[c] = pn;
            if (len_d[c] == MAX_LEN) begin
              fe_d[c]    = 1'b1;
              tr_d[c]    = 1'b1;
              post_d[c]  = '0;
              len_d[c]   = '0;
              state_d[c] = IDLE;
            end else if (!trig[c] && pn == '0) begin
              fe_d[c]    = 1'b1;
              post_d[c]  = '0;
              len_d[c]   = '0;
              state_d[c] = IDLE;
            end
          end
        end
        default: begin
          state_d[c] = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= IDLE;
        post_q[c]  <= '0;
        len_q[c]   <= '0;
      end
      dout_q  <= '0;
      valid_q <= '0;
      fs_q    <= '0;
      fe_q    <= '0;
      tr_q    <= '0;
      ttime_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= state_d[c];
        post_q[c]  <= post_d[c];
        len_q[c]   <= len_d[c];
      end
      dout_q  <= dout_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      tr_q    <= tr_d;
      ttime_q <= ttime_d;
    end
  end

  assign bus.DOUT        = dout_q;
  assign bus.VALID       = valid_q;
  assign bus.FRAME_START = fs_q;
  assign bus.FRAME_END   = fe_q;
  assign bus.TRUNCATED   = tr_q;
  assign bus.TRIG_TIME   = ttime_q;

endmodule

// File: tb/tb_multi_ch_trigger.sv
// Scenario bench for multi_ch_trigger
// with an expected-beat queue.
module tb_multi_ch_trigger;
  localparam int N    = 4;
  localparam int TW   = 256;
  localparam int ARW  = 12;
  localparam int TSW  = 48;
  localparam int MAXL = 50;
  localparam int PCW  = 8;
  localparam int SPT  = TW / 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]            ch_enable;
  logic                    mode;
  logic signed [ARW:0]     thr;
  logic signed [ARW-1:0]   base;
  logic [PCW-1:0]          post_len;
  logic [TSW-1:0]          cur_time = 48'h0000_1000_0000;
  logic signed [ARW-1:0]   hit_smp;

  int checks = 0;
  int errors = 0;

  always @(posedge clk) cur_time <= cur_time + 1;

  multi_ch_trigger_if #(
    .N_CH(N), .TDATA_WIDTH(TW),
    .TIME_STAMP_WIDTH(TSW)
  ) bus ();

  multi_ch_trigger #(
    .N_CH(N), .TDATA_WIDTH(TW),
    .ADC_RESOLUTION_WIDTH(ARW),
    .TIME_STAMP_WIDTH(TSW),
    .MAX_FRAME_LEN(MAXL),
    .POST_CNT_WIDTH(PCW)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus),
    .CH_ENABLE(ch_enable),
    .MODE(mode),
    .THRESHOLD_VAL(thr),
    .BASELINE(base),
    .POST_ACQUI_LEN(post_len),
    .CURRENT_TIME(cur_time)
  );

  typedef struct packed {
    logic [15:0]       flags;
    logic [N*TW-1:0]   data;
    logic [N-1:0]      tchk;
    logic [TSW-1:0]    t;
  } exp_t;

  exp_t sbq[$];

  // Idle slots sit at baseline; a hitting
  // channel carries hit_smp in one slot.
  function automatic logic [N*TW-1:0] mk_data(
    input logic [N-1:0] hm
  );
    logic [N*TW-1:0] d;
    logic [ARW-1:0]  s;
    d = '0;
    for (int c = 0; c < N; c++) begin
      for (int k = 0; k < SPT; k++) begin
        s = (hm[c] && k == (c*3+1) % SPT)
            ? hit_smp : base;
        d[c*TW+16*k +: 16] = {s, 4'hA};
      end
    end
    return d;
  endfunction

  task automatic beat(
    input string      nm,
    input int         idx,
    input logic [N-1:0] hm,
    input logic [N-1:0] tv,
    input logic       rdy,
    input logic [N-1:0] ev,
    input logic [N-1:0] efs,
    input logic [N-1:0] efe,
    input logic [N-1:0] etr
  );
    exp_t e;
    exp_t g;
    logic [15:0] obs;
    bus.TDATA            = mk_data(hm);
    bus.TVALID           = tv;
    bus.ALL_MODULE_READY = rdy;
    e.flags = {etr, efe, efs, ev};
    e.data  = bus.TDATA;
    e.tchk  = efs;
    e.t     = cur_time;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g   = sbq.pop_front();
    obs = {bus.TRUNCATED, bus.FRAME_END,
           bus.FRAME_START, bus.VALID};
    checks++;
    if (obs !== g.flags) begin
      errors++;
      $display("FAIL %s[%0d] tr/fe/fs/v got=%h want=%h",
               nm, idx, obs, g.flags);
    end
    checks++;
    if (bus.DOUT !== g.data) begin
      errors++;
      $display("FAIL %s[%0d] dout got=%h want=%h",
               nm, idx, bus.DOUT[63:0], g.data[63:0]);
    end
    for (int c = 0; c < N; c++) begin
      if (g.tchk[c]) begin
        checks++;
        if (bus.TRIG_TIME[c*TSW +: TSW] !== g.t) begin
          errors++;
          $display("FAIL %s[%0d] trig_time ch%0d got=%h want=%h",
                   nm, idx, c,
                   bus.TRIG_TIME[c*TSW +: TSW], g.t);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hit_smp = -300;
    bus.TDATA  = mk_data(4'hF);
    bus.TVALID = 4'hF;
    bus.ALL_MODULE_READY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.DOUT !== '0) begin
      errors++;
      $display("FAIL reset dout got=%h want=0",
               bus.DOUT[63:0]);
    end
    checks++;
    if ({bus.TRUNCATED, bus.FRAME_END,
         bus.FRAME_START, bus.VALID} !== 16'h0) begin
      errors++;
      $display("FAIL reset flags got=%h want=0",
               {bus.TRUNCATED, bus.FRAME_END,
                bus.FRAME_START, bus.VALID});
    end
    checks++;
    if (bus.TRIG_TIME !== '0) begin
      errors++;
      $display("FAIL reset trig_time got=%h want=0",
               bus.TRIG_TIME);
    end
    rst = 1'b0;
  endtask

  task automatic test_threshold();
    mode = 1'b0;
    ch_enable = 4'hF;
    post_len = 8'd0;
    hit_smp = -399;
    beat("thr_eq", 0, 4'h1, 4'hF, 1'b1,
         4'h0, 4'h0, 4'h0, 4'h0);
    hit_smp = -398;
    beat("thr_gt", 1, 4'h1, 4'hF, 1'b1,
         4'h1, 4'h1, 4'h0, 4'h0);
    beat("post0", 2, 4'h0, 4'hF, 1'b1,
         4'h1, 4'h0, 4'h1, 4'h0);
    hit_smp = -300;
    ch_enable = 4'b1101;
    beat("ch_dis", 3, 4'h2, 4'hF, 1'b1,
         4'h0, 4'h0, 4'h0, 4'h0);
    ch_enable = 4'hF;
    beat("tv_low", 4, 4'h1, 4'hE, 1'b1,
         4'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic test_frame(input logic md,
                            input logic [N-1:0] en);
    logic [N-1:0] m;
    mode = md;
    ch_enable = en;
    post_len = 8'd19;
    hit_smp = -300;
    m = md ? en : 4'h1;
    for (int i = 1; i <= 35; i++) begin
      beat(md ? "coinc" : "indep", i,
           (i <= 10) ? 4'h1 : 4'h0, 4'hF, 1'b1,
           (i <= 29) ? m : 4'h0,
           (i == 1)  ? m : 4'h0,
           (i == 29) ? m : 4'h0,
           4'h0);
    end
    mode = 1'b0;
    ch_enable = 4'hF;
  endtask

  task automatic test_truncate();
    post_len = 8'd2;
    for (int i = 1; i <= 85; i++) begin
      beat("trunc", i,
           (i <= 80) ? 4'h1 : 4'h0, 4'hF, 1'b1,
           (i <= 82) ? 4'h1 : 4'h0,
           (i == 1 || i == 51) ? 4'h1 : 4'h0,
           (i == 50 || i == 82) ? 4'h1 : 4'h0,
           (i == 50) ? 4'h1 : 4'h0);
    end
  endtask

  task automatic test_ready();
    post_len = 8'd1;
    beat("rdy", 1, 4'h1, 4'hF, 1'b0,
         4'h0, 4'h0, 4'h0, 4'h0);
    beat("rdy", 2, 4'h1, 4'hF, 1'b1,
         4'h1, 4'h1, 4'h0, 4'h0);
    beat("rdy", 3, 4'h1, 4'hF, 1'b0,
         4'h1, 4'h0, 4'h0, 4'h0);
    beat("rdy", 4, 4'h0, 4'hF, 1'b0,
         4'h1, 4'h0, 4'h1, 4'h0);
    beat("rdy", 5, 4'h1, 4'hF, 1'b0,
         4'h0, 4'h0, 4'h0, 4'h0);
    beat("rdy", 6, 4'h1, 4'hF, 1'b1,
         4'h1, 4'h1, 4'h0, 4'h0);
    beat("rdy", 7, 4'h0, 4'hF, 1'b1,
         4'h1, 4'h0, 4'h1, 4'h0);
  endtask

  task automatic test_gap();
    post_len = 8'd3;
    beat("gap", 1, 4'h1, 4'hF, 1'b1,
         4'h1, 4'h1, 4'h0, 4'h0);
    beat("gap", 2, 4'h0, 4'hF, 1'b1,
         4'h1, 4'h0, 4'h0, 4'h0);
    beat("gap", 3, 4'h0, 4'hE, 1'b1,
         4'h0, 4'h0, 4'h0, 4'h0);
    beat("gap", 4, 4'h1, 4'hE, 1'b1,
         4'h0, 4'h0, 4'h0, 4'h0);
    beat("gap", 5, 4'h0, 4'hE, 1'b1,
         4'h0, 4'h0, 4'h0, 4'h0);
    beat("gap", 6, 4'h0, 4'hF, 1'b1,
         4'h1, 4'h0, 4'h0, 4'h0);
    beat("gap", 7, 4'h0, 4'hF, 1'b1,
         4'h1, 4'h0, 4'h1, 4'h0);
    beat("gap", 8, 4'h0, 4'hF, 1'b1,
         4'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic test_back_to_back();
    post_len = 8'd0;
    for (int i = 1; i <= 4; i++) begin
      beat("b2b", i,
           i[0] ? 4'h1 : 4'h0, 4'hF, 1'b1,
           4'h1,
           i[0] ? 4'h1 : 4'h0,
           i[0] ? 4'h0 : 4'h1,
           4'h0);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] obs;
    post_len = 8'd10;
    for (int i = 1; i <= 4; i++) begin
      beat("rmid", i, 4'h1, 4'hF, 1'b1,
           4'h1, (i == 1) ? 4'h1 : 4'h0,
           4'h0, 4'h0);
    end
    rst = 1'b1;
    bus.TDATA = mk_data(4'h1);
    @(posedge clk);
    #1;
    obs = {bus.TRUNCATED, bus.FRAME_END,
           bus.FRAME_START, bus.VALID};
    checks++;
    if (obs !== 16'h0) begin
      errors++;
      $display("FAIL rmid_rst flags got=%h want=0",
               obs);
    end
    checks++;
    if (bus.DOUT !== '0 || bus.TRIG_TIME !== '0) begin
      errors++;
      $display("FAIL rmid_rst data got=%h/%h want=0",
               bus.DOUT[63:0], bus.TRIG_TIME[47:0]);
    end
    rst = 1'b0;
    post_len = 8'd0;
    beat("rrel", 1, 4'h0, 4'hF, 1'b1,
         4'h0, 4'h0, 4'h0, 4'h0);
    beat("rrel", 2, 4'h1, 4'hF, 1'b1,
         4'h1, 4'h1, 4'h0, 4'h0);
    beat("rrel", 3, 4'h0, 4'hF, 1'b1,
         4'h1, 4'h0, 4'h1, 4'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    mode      = 1'b0;
    ch_enable = 4'hF;
    thr       = 13'sd1638;
    base      = -12'sd2037;
    post_len  = '0;
    hit_smp   = -300;
    bus.TDATA = '0;
    bus.TVALID = '0;
    bus.ALL_MODULE_READY = 1'b0;
    test_reset();
    test_threshold();
    test_frame(1'b0, 4'hF);
    test_frame(1'b1, 4'b1011);
    test_truncate();
    test_ready();
    test_gap();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
